neuron_driver: RTL and testbench

- Initiator side of the CORDIC neuron interface: sequences a multi-input dot product plus activation through a single neuron instance.
- Holds up to DEPTH input/weight pairs in a local operand buffer and issues one neuron run per term.
- The linear-mode result of each run is fed back as the next run's Yo (accumulator); the last term runs with activation enabled.
- Returns the final linear, sinh and cosh values on a valid/ready result port.

---
 rtl/neuron_driver_pkg.sv | 16 +
 rtl/neuron_driver_operand_buf.sv | 30 +++
 rtl/neuron_driver.sv | 201 ++++++++++++++++++++
 tb/tb_neuron_driver.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_driver_pkg.sv
// Shared constants and FSM encoding for the CORDIC neuron driver.
package neuron_driver_pkg;

  localparam int DEF_WIDTH   = 15;
  localparam int DEF_AW      = 3;
  localparam int DEF_TIMEOUT = 63;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

endpackage

// File: rtl/neuron_driver_operand_buf.sv
// DEPTH-entry input/weight register file: one write port, combinational read.
module neuron_operand_buf #(
  parameter int WIDTH = 15,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH:0] wx,
  input  logic [WIDTH:0] ww,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH:0] rx,
  output logic [WIDTH:0] rw
);

  logic [WIDTH:0] x_mem_r [0:(1<<AW)-1];
  logic [WIDTH:0] w_mem_r [0:(1<<AW)-1];

  // Operand storage, never cleared by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      x_mem_r[waddr] <= wx;
      w_mem_r[waddr] <= ww;
    end
  end

  assign rx = x_mem_r[raddr];
  assign rw = w_mem_r[raddr];

endmodule

// File: rtl/neuron_driver.sv
// Sequences a multi-term dot product plus activation through one CORDIC neuron,
// feeding each run's linear result back as the next run's accumulator.
module neuron_driver
  import neuron_driver_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int AW      = DEF_AW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_we,
  input  logic [AW-1:0]  load_addr,
  input  logic [WIDTH:0] load_x,
  input  logic [WIDTH:0] load_w,
  input  logic [WIDTH:0] bias,
  input  logic [AW:0]    n_terms,
  input  logic           start,
  output logic           busy,
  output logic           err,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [WIDTH:0] res_lin,
  output logic [WIDTH:0] res_sinh,
  output logic [WIDTH:0] res_cosh,
  output logic [WIDTH:0] nrn_Xo,
  output logic [WIDTH:0] nrn_Yo,
  output logic [WIDTH:0] nrn_Zo,
  output logic           nrn_reset,
  output logic           nrn_af_en,
  input  logic           nrn_complete,
  input  logic [WIDTH:0] nrn_Yout,
  input  logic [WIDTH:0] nrn_Sin_H,
  input  logic [WIDTH:0] nrn_Cos_H
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH  = (AW+1)'(1 << AW);
  localparam logic [AW-1:0] IDX_ONE    = AW'(1);

  function automatic logic bad_len(input logic [AW:0] n);
    bad_len = (n == '0) || (n > CNT_DEPTH);
  endfunction

  state_t         state_r, state_next_s;
  logic [AW-1:0]  idx_r, idx_next_s;
  logic [AW:0]    cnt_r, cnt_next_s;
  logic [WIDTH:0] acc_r, acc_next_s;
  logic [TW-1:0]  timer_r, timer_next_s;
  logic           busy_r, busy_next_s;
  logic           err_r, err_next_s;
  logic           valid_r, valid_next_s;
  logic           res_load_s, ops_load_s, af_next_s;
  logic [WIDTH:0] res_lin_r, res_sinh_r, res_cosh_r;
  logic [WIDTH:0] nrn_xo_r, nrn_yo_r, nrn_zo_r;
  logic           nrn_reset_r, nrn_af_en_r;
  logic [WIDTH:0] buf_x_s, buf_w_s;

  // Read at the next index so operand registers are loaded entering SETUP
  // and refreshed once more at launch, picking up late writes.
  neuron_operand_buf #(.WIDTH(WIDTH), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (load_we),
    .waddr (load_addr),
    .wx    (load_x),
    .ww    (load_w),
    .raddr (idx_next_s),
    .rx    (buf_x_s),
    .rw    (buf_w_s)
  );

  // Next-state and datapath control.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    cnt_next_s   = cnt_r;
    acc_next_s   = acc_r;
    timer_next_s = timer_r;
    busy_next_s  = busy_r;
    err_next_s   = err_r;
    valid_next_s = valid_r;
    res_load_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (bad_len(n_terms)) begin
            err_next_s = 1'b1;
          end else begin
            acc_next_s   = bias;
            cnt_next_s   = n_terms;
            idx_next_s   = '0;
            err_next_s   = 1'b0;
            busy_next_s  = 1'b1;
            state_next_s = ST_SETUP;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        timer_next_s = '0;
        state_next_s = ST_RUN;
      end
      ST_RUN: begin
        if (nrn_complete) begin
          state_next_s = ST_CAPTURE;
        end else if (timer_r == TIMER_LAST) begin
          err_next_s   = 1'b1;
          busy_next_s  = 1'b0;
          state_next_s = ST_IDLE;
        end else begin
          timer_next_s = timer_r + TW'(1);
        end
      end
      ST_CAPTURE: begin
        acc_next_s = nrn_Yout;
        if ({1'b0, idx_r} == cnt_r - CNT_ONE) begin
          res_load_s   = 1'b1;
          valid_next_s = 1'b1;
          state_next_s = ST_OUT;
        end else begin
          idx_next_s   = idx_r + IDX_ONE;
          state_next_s = ST_SETUP;
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          valid_next_s = 1'b0;
          busy_next_s  = 1'b0;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_OUT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  assign ops_load_s = (state_next_s == ST_SETUP) || (state_r == ST_SETUP);
  assign af_next_s  = ({1'b0, idx_next_s} == cnt_next_s - CNT_ONE);

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      cnt_r       <= '0;
      acc_r       <= '0;
      timer_r     <= '0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      valid_r     <= 1'b0;
      res_lin_r   <= '0;
      res_sinh_r  <= '0;
      res_cosh_r  <= '0;
      nrn_xo_r    <= '0;
      nrn_yo_r    <= '0;
      nrn_zo_r    <= '0;
      nrn_reset_r <= 1'b0;
      nrn_af_en_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      idx_r       <= idx_next_s;
      cnt_r       <= cnt_next_s;
      acc_r       <= acc_next_s;
      timer_r     <= timer_next_s;
      busy_r      <= busy_next_s;
      err_r       <= err_next_s;
      valid_r     <= valid_next_s;
      nrn_reset_r <= (state_next_s == ST_RUN);
      if (res_load_s) begin
        res_lin_r  <= nrn_Yout;
        res_sinh_r <= nrn_Sin_H;
        res_cosh_r <= nrn_Cos_H;
      end
      if (ops_load_s) begin
        nrn_xo_r    <= buf_x_s;
        nrn_yo_r    <= acc_next_s;
        nrn_zo_r    <= buf_w_s;
        nrn_af_en_r <= af_next_s;
      end
    end
  end

  assign busy      = busy_r;
  assign err       = err_r;
  assign res_valid = valid_r;
  assign res_lin   = res_lin_r;
  assign res_sinh  = res_sinh_r;
  assign res_cosh  = res_cosh_r;
  assign nrn_Xo    = nrn_xo_r;
  assign nrn_Yo    = nrn_yo_r;
  assign nrn_Zo    = nrn_zo_r;
  assign nrn_reset = nrn_reset_r;
  assign nrn_af_en = nrn_af_en_r;

endmodule

// File: tb/tb_neuron_driver.sv
// Directed bench for neuron_driver with a behavioural neuron (Q8 multiply-accumulate,
// completes 20 cycles after release from reset unless told to hang).
module tb_neuron_driver;

  logic        clk = 1'b0;
  logic        reset, load_we, start, res_ready;
  logic [2:0]  load_addr;
  logic [15:0] load_x, load_w, bias;
  logic [3:0]  n_terms;
  logic        busy, err, res_valid, nrn_reset, nrn_af_en;
  logic [15:0] res_lin, res_sinh, res_cosh, nrn_Xo, nrn_Yo, nrn_Zo;
  logic [15:0] nrn_Yout, nrn_Sin_H, nrn_Cos_H;
  logic        nrn_complete = 1'b0;
  logic [7:0]  mcnt = 8'd0;
  logic        hang = 1'b0;
  logic signed [31:0] prod;

  int vec = 0;
  int miss = 0;

  always #5 clk = ~clk;

  neuron_driver dut (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
    .load_x(load_x), .load_w(load_w), .bias(bias), .n_terms(n_terms),
    .start(start), .busy(busy), .err(err), .res_valid(res_valid),
    .res_ready(res_ready), .res_lin(res_lin), .res_sinh(res_sinh),
    .res_cosh(res_cosh), .nrn_Xo(nrn_Xo), .nrn_Yo(nrn_Yo), .nrn_Zo(nrn_Zo),
    .nrn_reset(nrn_reset), .nrn_af_en(nrn_af_en), .nrn_complete(nrn_complete),
    .nrn_Yout(nrn_Yout), .nrn_Sin_H(nrn_Sin_H), .nrn_Cos_H(nrn_Cos_H)
  );

  // Behavioural neuron: Yout = Yo + (Xo*Zo)>>8, arbitrary distinct sinh/cosh.
  assign prod      = $signed(nrn_Xo) * $signed(nrn_Zo);
  assign nrn_Yout  = nrn_Yo + prod[23:8];
  assign nrn_Sin_H = nrn_Yout ^ 16'h5A5A;
  assign nrn_Cos_H = nrn_Yout + 16'h0100;

  always @(posedge clk) begin
    if (!nrn_reset) begin
      mcnt         <= 8'd0;
      nrn_complete <= 1'b0;
    end else begin
      mcnt <= mcnt + 8'd1;
      if (!hang && mcnt == 8'd19) nrn_complete <= 1'b1;
    end
  end

  // Log operands at every neuron launch (rising nrn_reset).
  logic [15:0] log_x [0:31];
  logic [15:0] log_y [0:31];
  logic [15:0] log_z [0:31];
  logic        log_af [0:31];
  int          runs = 0;
  logic        prev_nr = 1'b0;

  always @(negedge clk) begin
    prev_nr <= nrn_reset;
    if (nrn_reset && !prev_nr) begin
      log_x[runs[4:0]]  <= nrn_Xo;
      log_y[runs[4:0]]  <= nrn_Yo;
      log_z[runs[4:0]]  <= nrn_Zo;
      log_af[runs[4:0]] <= nrn_af_en;
      runs <= runs + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] x, input logic [15:0] w);
    load_we = 1'b1; load_addr = a; load_x = x; load_w = w;
    tick();
    load_we = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [3:0] n);
    bias = b; n_terms = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_result(input int budget, output int cyc);
    cyc = 0;
    while (!res_valid && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!res_valid) begin
      vec++; miss++;
      $display("FAIL wait_result: res_valid=0 after %0d cycles, required 1", cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    vec++;
    if ({busy, err, res_valid, nrn_reset, nrn_af_en} !== 5'b0) begin
      miss++; $display("FAIL reset_ctrl: got %b, required 00000", {busy, err, res_valid, nrn_reset, nrn_af_en});
    end
    vec++;
    if ({res_lin, res_sinh, res_cosh, nrn_Xo, nrn_Yo, nrn_Zo} !== 96'b0) begin
      miss++; $display("FAIL reset_data: got %h, required 0", {res_lin, res_sinh, res_cosh, nrn_Xo, nrn_Yo, nrn_Zo});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int base, cyc;
    base = runs;
    load(3'd0, 16'h0100, 16'h0080);
    do_start(16'h0000, 4'd1);
    vec++;
    if (busy !== 1'b1) begin miss++; $display("FAIL single_busy: got %b, required 1", busy); end
    wait_result(100, cyc);
    vec++;
    if (cyc !== 23) begin miss++; $display("FAIL single_latency: got %0d, required 23", cyc); end
    vec++;
    if ({res_lin, res_sinh, res_cosh} !== {16'h0080, 16'h5ADA, 16'h0180}) begin
      miss++; $display("FAIL single_result: got %h %h %h, required 0080 5ada 0180", res_lin, res_sinh, res_cosh);
    end
    vec++;
    if (runs - base !== 1) begin miss++; $display("FAIL single_runs: got %0d, required 1", runs - base); end
    vec++;
    if ({log_x[base[4:0]], log_y[base[4:0]], log_z[base[4:0]], log_af[base[4:0]]} !== {16'h0100, 16'h0000, 16'h0080, 1'b1}) begin
      miss++; $display("FAIL single_ops: got %h %h %h %b, required 0100 0000 0080 1",
                       log_x[base[4:0]], log_y[base[4:0]], log_z[base[4:0]], log_af[base[4:0]]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++;
      if ({res_valid, res_lin} !== {1'b1, 16'h0080}) begin
        miss++; $display("FAIL single_hold: got %b %h, required 1 0080", res_valid, res_lin);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    vec++;
    if ({res_valid, busy} !== 2'b00) begin miss++; $display("FAIL single_release: got %b, required 00", {res_valid, busy}); end
  endtask

  task automatic test_three();
    int base, cyc;
    logic [15:0] ex [0:2];
    logic [15:0] ey [0:2];
    logic [15:0] ez [0:2];
    logic        ea [0:2];
    ex = '{16'h0100, 16'h0200, 16'hFF00};
    ez = '{16'h0080, 16'h0040, 16'h0100};
    ey = '{16'h0040, 16'h00C0, 16'h0140};
    ea = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) load(3'(i), ex[i], ez[i]);
    base = runs;
    do_start(16'h0040, 4'd3);
    wait_result(200, cyc);
    vec++;
    if (runs - base !== 3) begin miss++; $display("FAIL three_runs: got %0d, required 3", runs - base); end
    for (int i = 0; i < 3; i++) begin
      vec++;
      if ({log_x[(base+i)%32], log_y[(base+i)%32], log_z[(base+i)%32], log_af[(base+i)%32]} !== {ex[i], ey[i], ez[i], ea[i]}) begin
        miss++; $display("FAIL three_ops[%0d]: got %h %h %h %b, required %h %h %h %b", i,
                         log_x[(base+i)%32], log_y[(base+i)%32], log_z[(base+i)%32], log_af[(base+i)%32],
                         ex[i], ey[i], ez[i], ea[i]);
      end
    end
    vec++;
    if ({res_lin, res_sinh, res_cosh} !== {16'h0040, 16'h5A1A, 16'h0140}) begin
      miss++; $display("FAIL three_result: got %h %h %h, required 0040 5a1a 0140", res_lin, res_sinh, res_cosh);
    end
  endtask

  task automatic test_back_pressure();
    int base;
    base = runs;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin bias = 16'h0000; n_terms = 4'd1; start = 1'b1; end
      else start = 1'b0;
      tick();
      vec++;
      if ({res_valid, busy, res_lin, res_sinh, res_cosh} !== {2'b11, 16'h0040, 16'h5A1A, 16'h0140}) begin
        miss++; $display("FAIL bp_hold[%0d]: got %b %b %h %h %h, required 1 1 0040 5a1a 0140",
                         i, res_valid, busy, res_lin, res_sinh, res_cosh);
      end
    end
    start = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    vec++;
    if ({res_valid, busy} !== 2'b00) begin miss++; $display("FAIL bp_release: got %b, required 00", {res_valid, busy}); end
    tick(); tick(); tick();
    vec++;
    if ({nrn_reset, busy, runs - base} !== {2'b00, 32'd0}) begin
      miss++; $display("FAIL bp_start_ignored: nrn_reset=%b busy=%b runs=%0d, required 0 0 0", nrn_reset, busy, runs - base);
    end
  endtask

  task automatic test_timeout();
    int cyc, n;
    hang = 1'b1;
    do_start(16'h0000, 4'd1);
    tick();
    vec++;
    if (nrn_reset !== 1'b1) begin miss++; $display("FAIL to_launch: nrn_reset=%b, required 1", nrn_reset); end
    n = 0;
    while (!err && n < 200) begin tick(); n++; end
    vec++;
    if (n !== 63) begin miss++; $display("FAIL to_cycles: got %0d, required 63", n); end
    vec++;
    if ({err, busy, res_valid, nrn_reset} !== 4'b1000) begin
      miss++; $display("FAIL to_state: got %b, required 1000", {err, busy, res_valid, nrn_reset});
    end
    hang = 1'b0;
    do_start(16'h0000, 4'd1);
    vec++;
    if ({err, busy} !== 2'b01) begin miss++; $display("FAIL to_restart: got %b, required 01", {err, busy}); end
    wait_result(100, cyc);
    vec++;
    if (res_lin !== 16'h0080) begin miss++; $display("FAIL to_result: got %h, required 0080", res_lin); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic test_bad_len();
    int base, cyc;
    logic [3:0] bad [0:1];
    bad = '{4'd0, 4'd9};
    for (int k = 0; k < 2; k++) begin
      base = runs;
      do_start(16'h0000, bad[k]);
      vec++;
      if ({err, busy} !== 2'b10) begin miss++; $display("FAIL badlen_%0d: got %b, required 10", bad[k], {err, busy}); end
      tick(); tick(); tick();
      vec++;
      if ({nrn_reset, runs - base} !== {1'b0, 32'd0}) begin
        miss++; $display("FAIL badlen_%0d_quiet: nrn_reset=%b runs=%0d, required 0 0", bad[k], nrn_reset, runs - base);
      end
      do_start(16'h0000, 4'd1);
      vec++;
      if (err !== 1'b0) begin miss++; $display("FAIL badlen_%0d_clear: got %b, required 0", bad[k], err); end
      wait_result(100, cyc);
      res_ready = 1'b1; tick(); res_ready = 1'b0;
    end
  endtask

  task automatic test_reset_midrun();
    int base, n, cyc;
    base = runs;
    do_start(16'h0040, 4'd3);
    n = 0;
    while (runs - base < 2 && n < 200) begin tick(); n++; end
    tick(); tick(); tick();
    vec++;
    if ({nrn_reset, nrn_Yo} !== {1'b1, 16'h00C0}) begin
      miss++; $display("FAIL mid_run2: nrn_reset=%b Yo=%h, required 1 00c0", nrn_reset, nrn_Yo);
    end
    reset = 1'b0;
    tick();
    vec++;
    if ({busy, err, res_valid, nrn_reset, nrn_af_en, res_lin, res_sinh, res_cosh, nrn_Xo, nrn_Yo, nrn_Zo} !== 101'b0) begin
      miss++; $display("FAIL mid_reset: got %h, required 0",
                       {busy, err, res_valid, nrn_reset, nrn_af_en, res_lin, res_sinh, res_cosh, nrn_Xo, nrn_Yo, nrn_Zo});
    end
    reset = 1'b1;
    tick();
    base = runs;
    do_start(16'h0040, 4'd3);
    wait_result(200, cyc);
    vec++;
    if ({res_lin, runs - base} !== {16'h0040, 32'd3}) begin
      miss++; $display("FAIL mid_rerun: got %h runs=%0d, required 0040 3", res_lin, runs - base);
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load_we = 1'b0; start = 1'b0; res_ready = 1'b0;
    load_addr = 3'd0; load_x = 16'h0000; load_w = 16'h0000;
    bias = 16'h0000; n_terms = 4'd0;
    test_reset();
    test_single();
    test_three();
    test_back_pressure();
    test_timeout();
    test_bad_len();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
